video_pixel_out: RTL and testbench

- Downstream stage of the video timing/address generator.
- Captures each RAM byte fetched during phi2 low and serializes it into 6-bit RGB (RRGGBB) pixels at master_clock rate.
- Two modes: 64-colour (one pixel per fetch, 256x240 active) and 2-colour (two pixels per fetch, 512x240 active).
- Re-times hsync/vsync/visible so sync edges stay aligned with the pixel stream at the DAC resistor ladder.

---
 rtl/video_pixel_out.sv | 142 ++++++++++++++
 tb/tb_video_pixel_out.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/video_pixel_out.sv
// Captures RAM bytes fetched in phi2-low and serialises them into RRGGBB pixels, with syncs re-timed to match.
// Optional macro VIDEO_BORDER_COLOR_EN adds a border colour register shown during non-sync blanking.
module video_pixel_out #(
  parameter int SYNC_DELAY = 2,
  parameter int COLOR_BITS = 6
) (
  input  logic                  master_clock,
  input  logic                  reset,
  input  logic                  phi2,
  input  logic [7:0]            ram_data,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  visible_in,
  input  logic                  mode_hi,
  input  logic                  reg_we,
  input  logic [1:0]            reg_sel,
  input  logic [COLOR_BITS-1:0] reg_data,
  output logic [COLOR_BITS-1:0] rgb,
  output logic                  hsync_out,
  output logic                  vsync_out
);

  typedef enum logic [1:0] {PH_IDLE, PH_A, PH_B, PH_HOLD} phase_t;

  phase_t                phase_q, phase_d;
  logic [7:0]            cap_q, cap_d;
  logic                  mode_q, mode_d;
  logic [COLOR_BITS-1:0] pix_q, pix_d;
  logic [COLOR_BITS-1:0] fg_q, fg_d;
  logic [COLOR_BITS-1:0] bg_q, bg_d;
  logic [SYNC_DELAY-1:0] hs_q, hs_d;
  logic [SYNC_DELAY-1:0] vs_q, vs_d;
  logic [SYNC_DELAY-1:0] vis_q, vis_d;
`ifdef VIDEO_BORDER_COLOR_EN
  logic [COLOR_BITS-1:0] border_q, border_d;
`endif

  always_comb begin
    phase_d = phase_q;
    cap_d   = cap_q;
    mode_d  = mode_q;
    if (!phi2) begin
      // A fetch always restarts the pair, even if the previous byte was not finished.
      phase_d = PH_A;
      cap_d   = ram_data;
      mode_d  = mode_hi;
    end else begin
      case (phase_q)
        PH_A:    phase_d = PH_B;
        PH_B:    phase_d = PH_HOLD;
        default: phase_d = phase_q;
      endcase
    end
  end

  always_comb begin
    pix_d = pix_q;
    case (phase_q)
      PH_IDLE: pix_d = '0;
      PH_A:    pix_d = mode_q ? (cap_q[7] ? fg_q : bg_q) : cap_q[COLOR_BITS-1:0];
      PH_B:    pix_d = mode_q ? (cap_q[6] ? fg_q : bg_q) : cap_q[COLOR_BITS-1:0];
      default: pix_d = pix_q;
    endcase
  end

  always_comb begin
    fg_d = fg_q;
    bg_d = bg_q;
`ifdef VIDEO_BORDER_COLOR_EN
    border_d = border_q;
`endif
    if (reg_we) begin
      case (reg_sel)
        2'd0:    fg_d = reg_data;
        2'd1:    bg_d = reg_data;
`ifdef VIDEO_BORDER_COLOR_EN
        2'd2:    border_d = reg_data;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    vis_d = vis_q;
    hs_d[0]  = hsync_in;
    vs_d[0]  = vsync_in;
    vis_d[0] = visible_in;
    for (int i = 1; i < SYNC_DELAY; i++) begin
      hs_d[i]  = hs_q[i-1];
      vs_d[i]  = vs_q[i-1];
      vis_d[i] = vis_q[i-1];
    end
  end

  always_ff @(posedge master_clock) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      cap_q   <= '0;
      mode_q  <= 1'b0;
      pix_q   <= '0;
      fg_q    <= '1;
      bg_q    <= '0;
      hs_q    <= '1;
      vs_q    <= '1;
      vis_q   <= '0;
`ifdef VIDEO_BORDER_COLOR_EN
      border_q <= '0;
`endif
    end else begin
      phase_q <= phase_d;
      cap_q   <= cap_d;
      mode_q  <= mode_d;
      pix_q   <= pix_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      vis_q   <= vis_d;
`ifdef VIDEO_BORDER_COLOR_EN
      border_q <= border_d;
`endif
    end
  end

  assign hsync_out = hs_q[SYNC_DELAY-1];
  assign vsync_out = vs_q[SYNC_DELAY-1];

  // Blanking is decided from the last pipeline stage so it lines up with the delayed syncs.
  always_comb begin
    rgb = pix_q;
    if (!vis_q[SYNC_DELAY-1]) begin
      rgb = '0;
`ifdef VIDEO_BORDER_COLOR_EN
      if (hs_q[SYNC_DELAY-1] && vs_q[SYNC_DELAY-1]) rgb = border_q;
`endif
    end
  end

endmodule

// File: tb/tb_video_pixel_out.sv
// Self-checking bench for video_pixel_out: directed test-plan cases, then random traffic against a reference model.
// Define VIDEO_BORDER_COLOR_EN for both bench and RTL to exercise the border colour.
module tb_video_pixel_out;

  logic       master_clock = 1'b0;
  logic       reset, phi2, hsync_in, vsync_in, visible_in, mode_hi, reg_we;
  logic [7:0] ram_data;
  logic [1:0] reg_sel;
  logic [5:0] reg_data;
  logic [5:0] rgb;
  logic       hsync_out, vsync_out;

  int checks = 0;
  int failures = 0;

  video_pixel_out #(.SYNC_DELAY(2), .COLOR_BITS(6)) dut (
    .master_clock(master_clock), .reset(reset), .phi2(phi2), .ram_data(ram_data),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .visible_in(visible_in), .mode_hi(mode_hi),
    .reg_we(reg_we), .reg_sel(reg_sel), .reg_data(reg_data),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 master_clock = ~master_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs follow the inputs seen one edge earlier; the pixel
  // depends on how many edges have passed since the most recent fetch.
  int         cyc = 0;
  int         cap_edge = -1;
  bit         model_ok = 0;
  logic [7:0] m_cap;
  logic       m_mode;
  logic [5:0] m_fg, m_bg, m_border;
  logic       p_hs, p_vs, p_vis;
  logic       exp_hs, exp_vs, exp_vis;
  logic [5:0] exp_pix, exp_rgb;

  function automatic logic [5:0] pick(input logic [7:0] c, input logic m, input int b,
                                      input logic [5:0] f, input logic [5:0] g);
    if (!m) return c[5:0];
    return c[b] ? f : g;
  endfunction

  always @(posedge master_clock) begin
    int d;
    if (reset) begin
      model_ok = 1;
      exp_hs = 1; exp_vs = 1; exp_vis = 0; exp_pix = '0;
      p_hs = 1; p_vs = 1; p_vis = 0;
      cap_edge = -1; m_cap = '0; m_mode = 0;
      m_fg = 6'h3F; m_bg = 6'h00; m_border = 6'h00;
    end else begin
      exp_hs = p_hs; exp_vs = p_vs; exp_vis = p_vis;
      p_hs = hsync_in; p_vs = vsync_in; p_vis = visible_in;
      if (cap_edge < 0) exp_pix = '0;
      else begin
        d = cyc - 1 - cap_edge;
        if (d == 0)      exp_pix = pick(m_cap, m_mode, 7, m_fg, m_bg);
        else if (d == 1) exp_pix = pick(m_cap, m_mode, 6, m_fg, m_bg);
      end
      if (!phi2) begin
        m_cap = ram_data; m_mode = mode_hi; cap_edge = cyc;
      end
      if (reg_we) begin
        if (reg_sel == 2'd0) m_fg = reg_data;
        if (reg_sel == 2'd1) m_bg = reg_data;
`ifdef VIDEO_BORDER_COLOR_EN
        if (reg_sel == 2'd2) m_border = reg_data;
`endif
      end
    end
    exp_rgb = exp_vis ? exp_pix : 6'h00;
`ifdef VIDEO_BORDER_COLOR_EN
    if (!exp_vis && exp_hs && exp_vs) exp_rgb = m_border;
`endif
    cyc++;
  end

  always @(negedge master_clock) begin
    if (model_ok) begin
      check("model_rgb", {26'd0, rgb}, {26'd0, exp_rgb});
      check("model_hsync", {31'd0, hsync_out}, {31'd0, exp_hs});
      check("model_vsync", {31'd0, vsync_out}, {31'd0, exp_vs});
    end
  end

  task automatic tick();
    @(posedge master_clock);
    @(negedge master_clock);
  endtask

  initial begin
    int  low_cnt;
    bit  rgb_nz;
    reset = 1; phi2 = 1; ram_data = '0; hsync_in = 1; vsync_in = 1; visible_in = 0;
    mode_hi = 0; reg_we = 0; reg_sel = '0; reg_data = '0;
    tick(); tick();
    check("reset_rgb", {26'd0, rgb}, 32'h0);
    check("reset_hsync", {31'd0, hsync_out}, 32'h1);
    check("reset_vsync", {31'd0, vsync_out}, 32'h1);
    reset = 0;

    // 64-colour: E5 shows as 25 twice; top bits dropped
    visible_in = 1;
    repeat (3) tick();
    phi2 = 0; ram_data = 8'hE5; tick();
    phi2 = 1; tick();
    check("c64_first", {26'd0, rgb}, 32'h25);
    phi2 = 0; ram_data = 8'hC0; tick();
    check("c64_second", {26'd0, rgb}, 32'h25);
    phi2 = 1; tick();
    check("c64_top_bits_ignored", {26'd0, rgb}, 32'h00);

    // 2-colour with fg=30 bg=0C, then hold
    reg_we = 1; reg_sel = 2'd0; reg_data = 6'h30; tick();
    reg_sel = 2'd1; reg_data = 6'h0C; tick();
    reg_we = 0;
    mode_hi = 1; phi2 = 0; ram_data = 8'hA5; tick();
    phi2 = 1; tick();
    check("c2_10_first", {26'd0, rgb}, 32'h30);
    phi2 = 0; ram_data = 8'h6A; tick();
    check("c2_10_second", {26'd0, rgb}, 32'h0C);
    phi2 = 1; tick();
    check("c2_01_first", {26'd0, rgb}, 32'h0C);
    tick();
    check("c2_01_second", {26'd0, rgb}, 32'h30);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_repeat", {26'd0, rgb}, 32'h30);
    end
    phi2 = 0; ram_data = 8'h40; tick();
    phi2 = 1; tick();
    check("hold_resume", {26'd0, rgb}, 32'h0C);

    // 48-cycle hsync pulse during blanking
    visible_in = 0; mode_hi = 0;
    repeat (3) tick();
    hsync_in = 0; low_cnt = 0; rgb_nz = 0;
    tick();
    check("hsync_not_early", {31'd0, hsync_out}, 32'h1);
    for (int i = 0; i < 49; i++) begin
      if (i == 47) hsync_in = 1;
      phi2 = ~phi2; ram_data = 8'($urandom);
      tick();
      if (!hsync_out) low_cnt++;
      if (rgb != 6'h00) rgb_nz = 1;
    end
    check("hsync_width", low_cnt, 32'd48);
    check("hsync_rgb_black", {31'd0, rgb_nz}, 32'h0);
    check("hsync_released", {31'd0, hsync_out}, 32'h1);

    // reset in PH_B with rgb=3F
    visible_in = 1; phi2 = 1; mode_hi = 0;
    repeat (2) tick();
    phi2 = 0; ram_data = 8'h3F; tick();
    phi2 = 1; tick();
    check("pre_reset_rgb", {26'd0, rgb}, 32'h3F);
    reset = 1; tick();
    check("midline_reset_rgb", {26'd0, rgb}, 32'h0);
    check("midline_reset_hs", {31'd0, hsync_out}, 32'h1);
    check("midline_reset_vs", {31'd0, vsync_out}, 32'h1);
    reset = 0; tick();
    mode_hi = 1; phi2 = 0; ram_data = 8'h80; tick();
    phi2 = 1; tick();
    check("reset_fg", {26'd0, rgb}, 32'h3F);
    tick();
    check("reset_bg", {26'd0, rgb}, 32'h00);

    // border register
    visible_in = 0; hsync_in = 1; vsync_in = 1; mode_hi = 0;
    reg_we = 1; reg_sel = 2'd2; reg_data = 6'h03; tick();
    reg_we = 0; tick(); tick();
`ifdef VIDEO_BORDER_COLOR_EN
    check("border_shown", {26'd0, rgb}, 32'h03);
    vsync_in = 0; tick();
    check("border_vsync_lag", {26'd0, rgb}, 32'h03);
    tick();
    check("border_vsync_black", {26'd0, rgb}, 32'h00);
`else
    check("border_absent", {26'd0, rgb}, 32'h00);
`endif
    vsync_in = 1;

    // random traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      phi2       = ($urandom_range(0, 9) < 6);
      ram_data   = 8'($urandom);
      mode_hi    = 1'($urandom);
      visible_in = ($urandom_range(0, 9) < 7);
      hsync_in   = ($urandom_range(0, 19) != 0);
      vsync_in   = ($urandom_range(0, 29) != 0);
      reg_we     = ($urandom_range(0, 9) == 0);
      reg_sel    = 2'($urandom);
      reg_data   = 6'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
